// File: rtl/minrv32_mem_model.sv
// minrv32_mem_model: single-port 32-bit word memory on the minrv32 native bus.
// Each request waits a number of cycles, commits its read and write on the edge
// that enters RESP, and pulses mem_ready for exactly one cycle.
// Out-of-range and misaligned addresses raise the sticky addr_err flag.
// Dropping mem_valid while waiting raises the sticky proto_err flag.
// Optional feature macro: MINRV32_MEM_RAND_WAIT_EN. When it is defined, each
// access waits a pseudo-random number of cycles taken from a 16-bit LFSR.
// When it is undefined, every access waits exactly WAIT_CYCLES cycles.
// Memory contents have no reset and survive reset. Benches preload the array
// `mem` hierarchically.

module minrv32_mem_model #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned WAIT_BITS   = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        addr_err,
    output logic        proto_err,
    output logic [31:0] fetch_count
);

    // Word-index width. DEPTH is a power of two, at least 2 and at most 2^29.
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    // The wait counter must hold the fixed wait count and every random wait value.
    localparam int unsigned FIX_W = $clog2(WAIT_CYCLES + 1);
    localparam int unsigned CNT_W = (FIX_W > WAIT_BITS) ? FIX_W : WAIT_BITS;

    // Reject parameter values the design cannot honour when it is elaborated.
    if (LFSR_SEED == 16'h0) begin : g_seed_check
        $error("minrv32_mem_model: LFSR_SEED must be non-zero");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("minrv32_mem_model: DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   wait_value;
    logic               commit;
    logic               proto_hit;

    logic [31:0]        mem [DEPTH];

    logic               addr_oob;
    logic               misaligned;
    logic [ADDR_W-1:0]  word_idx;

    assign addr_oob   = |mem_addr[31:ADDR_W+2];
    assign misaligned = |mem_addr[1:0];
    assign word_idx   = mem_addr[ADDR_W+1:2];

`ifdef MINRV32_MEM_RAND_WAIT_EN
    logic [15:0] lfsr;

    // Galois LFSR for x^16+x^14+x^13+x^11+1. It free-runs every cycle out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign wait_value = CNT_W'(lfsr[WAIT_BITS-1:0]);
`else
    assign wait_value = CNT_W'(WAIT_CYCLES);
`endif

    // Next-state logic. The wait value is sampled only in IDLE.
    // The access commits on the edge that enters RESP.
    // Losing mem_valid while waiting takes priority over completing the access.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        proto_hit  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_valid) begin
                    if (wait_value == '0) begin
                        state_next = ST_RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = wait_value;
                    end
                end
            end
            ST_WAIT: begin
                if (!mem_valid) begin
                    proto_hit  = 1'b1;
                    state_next = ST_IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    commit     = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign mem_ready = (state == ST_RESP);

    // State register and wait counter. Reset abandons any access in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Read data capture and the sticky error flags. Read data holds between accesses.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_rdata <= '0;
            addr_err  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (commit) begin
                mem_rdata <= addr_oob ? 32'h0 : mem[word_idx];
                if (addr_oob || misaligned) begin
                    addr_err <= 1'b1;
                end
            end
            if (proto_hit) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Byte-masked write at commit. The array is never cleared.
    // An out-of-range address writes nothing.
    always_ff @(posedge clock) begin
        if (!reset && commit && !addr_oob) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) begin
                    mem[word_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Count completed instruction fetches. The count wraps naturally at 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count <= '0;
        end else if ((state == ST_RESP) && mem_instr) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule
